// File: rtl/acq_sequencer.sv
// Acquisition sequencer: orders the capture-chain resets, arms the trigger and counts beats.
// Optional watchdog in ARMED under `ACQ_TIMEOUT_EN (adds timeout_cycles / timed_out).
module acq_sequencer #(
  parameter int SETTLE_WIDTH = 16,
  parameter int LEN_WIDTH    = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SETTLE_WIDTH-1:0] settle_cycles,
  input  logic [LEN_WIDTH-1:0]    capture_len,
  input  logic                    trg_event,
  input  logic                    s_beat,
`ifdef ACQ_TIMEOUT_EN
  input  logic [LEN_WIDTH-1:0]    timeout_cycles,
  output logic                    timed_out,
`endif
  output logic                    nreset_adc,
  output logic                    nreset_axis_writer,
  output logic                    nreset_trg,
  output logic                    nreset_max_sum,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_WIDTH-1:0]    beat_cnt,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADC_UP  = 3'd1,
    S_PIPE_UP = 3'd2,
    S_ARMED   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [SETTLE_WIDTH-1:0] SET_ONE = SETTLE_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]    LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]    LEN_MAX = '1;

  state_t                  r_state, w_ns;
  logic                    r_start_d, w_start_edge;
  logic [SETTLE_WIDTH-1:0] r_settle, w_settle_nx;
  logic [LEN_WIDTH-1:0]    r_len, w_len_nx;
  logic [LEN_WIDTH-1:0]    r_beat, w_beat_nx;
  logic                    r_adc, r_wr, r_trg, r_ms, r_busy, r_done;
`ifdef ACQ_TIMEOUT_EN
  logic [LEN_WIDTH-1:0]    r_wd, w_wd_nx;
  logic                    r_to, w_to_nx;
`endif

  assign w_start_edge = start & ~r_start_d;

  always_comb begin
    w_ns        = r_state;
    w_settle_nx = r_settle;
    w_len_nx    = r_len;
    w_beat_nx   = r_beat;
`ifdef ACQ_TIMEOUT_EN
    w_wd_nx     = '0;
    w_to_nx     = r_to;
`endif
    if (abort) begin
      w_ns = S_IDLE;
`ifdef ACQ_TIMEOUT_EN
      w_to_nx = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            w_ns        = S_ADC_UP;
            w_settle_nx = settle_cycles;
            w_len_nx    = capture_len;
            w_beat_nx   = '0;
`ifdef ACQ_TIMEOUT_EN
            w_to_nx     = 1'b0;
`endif
          end
        end
        S_ADC_UP: begin
          if (r_settle == '0) w_ns = S_PIPE_UP;
          else                w_settle_nx = r_settle - SET_ONE;
        end
        S_PIPE_UP: w_ns = S_ARMED;
        S_ARMED: begin
          if (trg_event) begin
            w_ns = (r_len == '0) ? S_DONE : S_CAPTURE;
`ifdef ACQ_TIMEOUT_EN
          end else if (timeout_cycles != '0 && r_wd == timeout_cycles - LEN_ONE) begin
            w_ns    = S_DONE;
            w_to_nx = 1'b1;
          end else begin
            w_wd_nx = r_wd + LEN_ONE;
`endif
          end
        end
        S_CAPTURE: begin
          if (s_beat) begin
            if (r_beat != LEN_MAX) w_beat_nx = r_beat + LEN_ONE;
            if (r_beat == r_len - LEN_ONE) w_ns = S_DONE;
          end
        end
        default: w_ns = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b1;
      r_settle  <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_adc     <= 1'b0;
      r_wr      <= 1'b0;
      r_trg     <= 1'b0;
      r_ms      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
      r_wd      <= '0;
      r_to      <= 1'b0;
`endif
    end else begin
      r_state   <= w_ns;
      r_start_d <= start;
      r_settle  <= w_settle_nx;
      r_len     <= w_len_nx;
      r_beat    <= w_beat_nx;
      r_adc     <= (w_ns != S_IDLE);
      r_wr      <= (w_ns == S_PIPE_UP) || (w_ns == S_ARMED) || (w_ns == S_CAPTURE) || (w_ns == S_DONE);
      r_ms      <= (w_ns == S_PIPE_UP) || (w_ns == S_ARMED) || (w_ns == S_CAPTURE) || (w_ns == S_DONE);
      r_trg     <= (w_ns == S_ARMED) || (w_ns == S_CAPTURE);
      r_busy    <= (w_ns == S_ADC_UP) || (w_ns == S_PIPE_UP) || (w_ns == S_ARMED) || (w_ns == S_CAPTURE);
      r_done    <= (w_ns == S_DONE);
`ifdef ACQ_TIMEOUT_EN
      r_wd      <= w_wd_nx;
      r_to      <= w_to_nx;
`endif
    end
  end

  assign nreset_adc         = r_adc;
  assign nreset_axis_writer = r_wr;
  assign nreset_trg         = r_trg;
  assign nreset_max_sum     = r_ms;
  assign busy               = r_busy;
  assign done               = r_done;
  assign beat_cnt           = r_beat;
  assign state              = r_state;
`ifdef ACQ_TIMEOUT_EN
  assign timed_out          = r_to;
`endif

endmodule
